// File: rtl/pcs_gray6_pkg.sv
// Shared definitions for the 6-entry PCS gearbox FIFO pointers.
// Both the write-side encoder and the read-side controller use this package.
//   G0..G5       : 6-state Gray code set. A code's index is its position in the set.
//   DEPTH        : number of FIFO entries.
//   gray6_to_bin : 4-bit code -> {valid, index[2:0]}. valid=0 for codes outside the set.
//   bin_to_gray6 : index 0..5 -> 4-bit code. Out-of-range indices return G0.
//   rd_state_t   : read-controller FSM states.
package pcs_gray6_pkg;

    localparam int DEPTH = 6;

    localparam logic [3:0] G0 = 4'b0000;
    localparam logic [3:0] G1 = 4'b0001;
    localparam logic [3:0] G2 = 4'b0011;
    localparam logic [3:0] G3 = 4'b0010;
    localparam logic [3:0] G4 = 4'b0110;
    localparam logic [3:0] G5 = 4'b0100;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } rd_state_t;

    function automatic logic [3:0] gray6_to_bin(input logic [3:0] g);
        logic [3:0] r;
        case (g)
            G0:      r = 4'b1_000;
            G1:      r = 4'b1_001;
            G2:      r = 4'b1_010;
            G3:      r = 4'b1_011;
            G4:      r = 4'b1_100;
            G5:      r = 4'b1_101;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] bin_to_gray6(input logic [2:0] b);
        logic [3:0] r;
        case (b)
            3'd0:    r = G0;
            3'd1:    r = G1;
            3'd2:    r = G2;
            3'd3:    r = G3;
            3'd4:    r = G4;
            3'd5:    r = G5;
            default: r = G0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcs_sync_ff.sv
// Plain multi-flop synchroniser for a bus that is already Gray coded
// (at most one bit changes per step, so per-bit synchronisation is safe).
//   clk   : destination clock
//   reset : asynchronous, active-high; all stages clear to 0 (= G0)
//   d     : asynchronous input bus
//   q     : output of the last stage
module pcs_sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/graydecoder_rdctl_6.sv
// Read-side pointer controller of the 6-entry PCS gearbox FIFO.
// Synchronises and decodes the write pointer Gray code, checks each step,
// keeps the mod-6 read pointer and derives empty/level.
//   clk         : read-domain clock
//   reset       : asynchronous, active-high
//   wr_ptr_gray : write pointer (6-state Gray), asynchronous to clk
//   rd_en       : pop request for the head entry
//   clr_err     : one-cycle pulse, leaves FAULT and clears gray_err
//   rd_ptr      : binary read address 0..5
//   rd_ptr_gray : registered Gray form of rd_ptr for the write domain
//   rd_fire     : pop accepted this cycle
//   empty       : no readable entry (forced in INIT/FAULT)
//   level       : entries available, 0..5
//   gray_err    : sticky, illegal code or illegal step seen
//   underflow   : pop request refused this cycle
//   state_dbg   : current FSM state (rd_state_t encoding)
// Handshake: a pop happens on the rising edge where rd_en=1 and rd_fire=1;
// rd_fire never depends on anything but registered state and rd_en.
module graydecoder_rdctl_6
    import pcs_gray6_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] wr_ptr_gray,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [2:0] rd_ptr,
    output logic [3:0] rd_ptr_gray,
    output logic       rd_fire,
    output logic       empty,
    output logic [2:0] level,
    output logic       gray_err,
    output logic       underflow,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1) + 1;

    rd_state_t        state;
    logic [CNT_W-1:0] init_cnt;
    logic [2:0]       wr_bin;
    logic [3:0]       sync_gray;
    logic [3:0]       dec;
    logic             dec_valid;
    logic [2:0]       dec_bin;
    logic [2:0]       wr_bin_inc;
    logic             step_ok;
    logic [2:0]       rd_ptr_nxt;

    pcs_sync_ff #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (wr_ptr_gray),
        .q     (sync_gray)
    );

    assign dec       = gray6_to_bin(sync_gray);
    assign dec_valid = dec[3];
    assign dec_bin   = dec[2:0];

    // The write pointer may only stay put or advance by one (mod 6) per read clock.
    assign wr_bin_inc = (wr_bin == 3'd5) ? 3'd0 : 3'(wr_bin + 3'd1);
    assign step_ok    = dec_valid && ((dec_bin == wr_bin) || (dec_bin == wr_bin_inc));

    // 3-bit subtraction wraps mod 8; adding 6 when negative folds it into mod 6.
    always_comb begin
        level = 3'd0;
        if (wr_bin >= rd_ptr) begin
            level = 3'(wr_bin - rd_ptr);
        end else begin
            level = 3'(wr_bin - rd_ptr + 3'd6);
        end
    end

    assign empty      = (state != RUN) || (level == 3'd0);
    assign rd_fire    = rd_en && !empty;
    assign underflow  = rd_en && empty;
    assign rd_ptr_nxt = (rd_ptr == 3'd5) ? 3'd0 : 3'(rd_ptr + 3'd1);
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            init_cnt    <= '0;
            wr_bin      <= 3'd0;
            rd_ptr      <= 3'd0;
            rd_ptr_gray <= G0;
            gray_err    <= 1'b0;
        end else begin
            if (rd_fire) begin
                rd_ptr      <= rd_ptr_nxt;
                rd_ptr_gray <= bin_to_gray6(rd_ptr_nxt);
            end
            case (state)
                INIT: begin
                    if (step_ok) wr_bin <= dec_bin;
                    else         gray_err <= 1'b1;
                    if (init_cnt == CNT_W'(SYNC_STAGES)) begin
                        // An error caught while settling skips RUN entirely.
                        state <= (gray_err || !step_ok) ? FAULT : RUN;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (step_ok) begin
                        wr_bin <= dec_bin;
                    end else begin
                        gray_err <= 1'b1;
                        state    <= FAULT;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        state    <= INIT;
                        init_cnt <= '0;
                        gray_err <= 1'b0;
                        // Re-seed from whatever the write side currently shows, if decodable.
                        if (dec_valid) wr_bin <= dec_bin;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
